// File: rtl/data_memory_responder.sv
// ============================================================================
// data_memory_responder
// ----------------------------------------------------------------------------
// Byte RAM that serves the CPU's data port and also handles the host side of
// each processing run:
//   * before a run, a memory image is loaded from a host byte stream;
//   * during a run, the CPU reads the RAM asynchronously (registered onto
//     DATA_FROM_RAM) and writes one byte per CPU tick on the falling edge of
//     CPU_CLOCK;
//   * after PROCESS_FINISHED, a fixed result window is streamed back out.
//
// Parameters
//   ADDR_WIDTH  RAM depth is 2**ADDR_WIDTH bytes (CPU_ADDRESS aliases above it)
//   DUMP_BASE   first byte address sent in the result window
//   DUMP_LEN    number of bytes in the result window (1 .. 2**ADDR_WIDTH)
//
// Ports
//   CLOCK                  system clock (same net as the CPU's MAIN_CLOCK)
//   RESET_N                asynchronous active-low reset
//   HOST_LOAD_START        one-cycle request to begin an image load
//   HOST_RUN               one-cycle request to start CPU processing
//   HOST_VALID/DATA/LAST   image load stream
//   HOST_READY             load stream ready (high only while loading)
//   START_PROCESSING_FLAG  enables the CPU clock generator
//   CPU_CLOCK              CPU tick, derived from CLOCK
//   CPU_WRITE_EN           CPU write request
//   CPU_ADDRESS            CPU data address
//   CPU_DATA               CPU write data
//   PROCESS_FINISHED       CPU reports completion
//   DATA_FROM_RAM          registered read data for the CPU
//   OUT_VALID/DATA/LAST    result window stream
//   OUT_READY              result window stream ready
//   STATE                  current controller state, for debug
// ============================================================================
module data_memory_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int DUMP_BASE  = 0,
   parameter int DUMP_LEN   = 16
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        HOST_LOAD_START,
   input  logic        HOST_RUN,
   input  logic        HOST_VALID,
   input  logic [7:0]  HOST_DATA,
   input  logic        HOST_LAST,
   output logic        HOST_READY,
   output logic        START_PROCESSING_FLAG,
   input  logic        CPU_CLOCK,
   input  logic        CPU_WRITE_EN,
   input  logic [15:0] CPU_ADDRESS,
   input  logic [7:0]  CPU_DATA,
   input  logic        PROCESS_FINISHED,
   output logic [7:0]  DATA_FROM_RAM,
   output logic        OUT_VALID,
   output logic [7:0]  OUT_DATA,
   output logic        OUT_LAST,
   input  logic        OUT_READY,
   output logic [2:0]  STATE
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // The dump window start and end, reduced modulo the RAM depth so that a
   // window running past the top of memory wraps back to address zero.
   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(DUMP_BASE % DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((DUMP_BASE + DUMP_LEN - 1) % DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_MAX   = {ADDR_WIDTH{1'b1}};

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_READY = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_DUMP  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   logic [7:0]            mem [DEPTH];
   logic [2:0]            state_q;
   logic [2:0]            state_d;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [ADDR_WIDTH-1:0] ptr_d;
   logic                  clk_q;
   logic [7:0]            data_from_ram_q;
   logic                  host_ready_q;
   logic                  start_flag_q;
   logic                  out_valid_q;
   logic                  out_last_q;

   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic                  cpu_falling;
   logic                  host_fire;
   logic                  cpu_fire;
   logic                  out_fire;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [7:0]            mem_wdata;
   logic                  unused_addr_bits;

   // Upper CPU address bits are deliberately dropped so the RAM aliases.
   assign cpu_addr         = CPU_ADDRESS[ADDR_WIDTH-1:0];
   assign unused_addr_bits = ^CPU_ADDRESS;

   // A CPU tick ends on its falling edge; seeing the previous sample high and
   // the current one low gives exactly one write strobe per tick, and nothing
   // at all while CPU_CLOCK is parked high or low.
   assign cpu_falling = clk_q & ~CPU_CLOCK;

   // Handshakes are qualified by the registered state decode so that inputs
   // arriving in the wrong phase of the session are silently dropped.
   assign host_fire = (state_q == ST_LOAD) & HOST_VALID;
   assign cpu_fire  = (state_q == ST_RUN) & cpu_falling & CPU_WRITE_EN;
   assign out_fire  = (state_q == ST_DUMP) & OUT_READY;

   // Controller next-state and pointer logic. The one pointer serves both
   // as the load write address and as the dump read address, since loading
   // and dumping never overlap.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (HOST_LOAD_START) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         ST_LOAD: begin
            if (host_fire) begin
               ptr_d = ptr_q + 1'b1;
               if (HOST_LAST || (ptr_q == PTR_MAX)) begin
                  state_d = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (HOST_LOAD_START) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end else if (HOST_RUN) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (PROCESS_FINISHED) begin
               state_d = ST_DUMP;
               ptr_d   = BASE_ADDR;
            end
         end
         ST_DUMP: begin
            if (out_fire) begin
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (HOST_LOAD_START) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Single RAM write port shared by the host loader and the CPU. The two
   // sources live in different states, so they never collide.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = HOST_DATA;
      if (host_fire) begin
         mem_we    = 1'b1;
         mem_waddr = ptr_q;
         mem_wdata = HOST_DATA;
      end else if (cpu_fire) begin
         mem_we    = 1'b1;
         mem_waddr = cpu_addr;
         mem_wdata = CPU_DATA;
      end
   end

   // RAM array: synchronous write, no reset, so the image and any results
   // survive a mid-run reset.
   always_ff @(posedge CLOCK) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Controller state, pointer and the CPU clock history used for edge
   // detection.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         clk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         clk_q   <= CPU_CLOCK;
      end
   end

   // Status outputs are registered from the next-state values so they appear
   // together with the new state and are glitch-free toward the host.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         host_ready_q <= 1'b0;
         start_flag_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         host_ready_q <= (state_d == ST_LOAD);
         start_flag_q <= (state_d == ST_RUN);
         out_valid_q  <= (state_d == ST_DUMP);
         out_last_q   <= (state_d == ST_DUMP) && (ptr_d == LAST_ADDR);
      end
   end

   // CPU read data is resampled every cycle in every state. It captures the
   // array before the same edge's write lands, so a fresh write shows up on
   // the following cycle.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         data_from_ram_q <= 8'h00;
      end else begin
         data_from_ram_q <= mem[cpu_addr];
      end
   end

   assign HOST_READY            = host_ready_q;
   assign START_PROCESSING_FLAG = start_flag_q;
   assign OUT_VALID             = out_valid_q;
   assign OUT_LAST              = out_last_q;
   assign OUT_DATA              = mem[ptr_q];
   assign DATA_FROM_RAM         = data_from_ram_q;
   assign STATE                 = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// tb_data_memory_responder
// ----------------------------------------------------------------------------
// Drives data_memory_responder through directed sessions (load, run, dump,
// reset during load) followed by randomized sessions. A behavioural model of
// the session rules predicts every output each cycle; a few literal values
// taken straight from the stimulus pin the model itself.
// ============================================================================
module tb_data_memory_responder;

   localparam int DEPTH     = 256;
   localparam int DUMP_BASE = 0;
   localparam int DUMP_LEN  = 16;
   localparam int LAST_PTR  = (DUMP_BASE + DUMP_LEN - 1) % DEPTH;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start;
   logic        host_run;
   logic        host_valid;
   logic [7:0]  host_data;
   logic        host_last;
   logic        host_ready;
   logic        start_flag;
   logic        cpu_clk;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        finished;
   logic [7:0]  data_from_ram;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready;
   logic [2:0]  state;

   int checkCount = 0;
   int passCount  = 0;
   int cpu_phase  = 0;

   // Behavioural model of the session.
   int         m_state;
   int         m_ptr;
   int         m_addr;
   bit         m_clkq;
   logic [7:0] m_mem [DEPTH];
   bit         m_known [DEPTH];
   logic [7:0] m_rd;
   bit         m_rd_known;

   logic [7:0] load_bytes [DEPTH];
   logic [7:0] beat_data [DUMP_LEN];
   logic       beat_last [DUMP_LEN];

   data_memory_responder #(
      .ADDR_WIDTH (8),
      .DUMP_BASE  (DUMP_BASE),
      .DUMP_LEN   (DUMP_LEN)
   ) dut (
      .CLOCK                 (clk),
      .RESET_N               (rst_n),
      .HOST_LOAD_START       (load_start),
      .HOST_RUN              (host_run),
      .HOST_VALID            (host_valid),
      .HOST_DATA             (host_data),
      .HOST_LAST             (host_last),
      .HOST_READY            (host_ready),
      .START_PROCESSING_FLAG (start_flag),
      .CPU_CLOCK             (cpu_clk),
      .CPU_WRITE_EN          (cpu_we),
      .CPU_ADDRESS           (cpu_addr),
      .CPU_DATA              (cpu_data),
      .PROCESS_FINISHED      (finished),
      .DATA_FROM_RAM         (data_from_ram),
      .OUT_VALID             (out_valid),
      .OUT_DATA              (out_data),
      .OUT_LAST              (out_last),
      .OUT_READY             (out_ready),
      .STATE                 (state)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Lets n clock edges sample the currently driven inputs; returns 2 time
   // units after the last edge so new inputs can be driven safely.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Model update: applies the session rules on each edge. The read register
   // sees the memory as it was before this edge's write.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state    = 0;
         m_ptr      = 0;
         m_clkq     = 1'b0;
         m_rd       = 8'h00;
         m_rd_known = 1'b1;
      end else begin
         m_addr     = int'(cpu_addr) % DEPTH;
         m_rd       = m_mem[m_addr];
         m_rd_known = m_known[m_addr];
         case (m_state)
            0: if (load_start) begin
                  m_state = 1;
                  m_ptr   = 0;
               end
            1: if (host_valid) begin
                  m_mem[m_ptr]   = host_data;
                  m_known[m_ptr] = 1'b1;
                  if (host_last || m_ptr == DEPTH - 1) m_state = 2;
                  m_ptr = (m_ptr + 1) % DEPTH;
               end
            2: if (load_start) begin
                  m_state = 1;
                  m_ptr   = 0;
               end else if (host_run) begin
                  m_state = 3;
               end
            3: begin
                  if (m_clkq && !cpu_clk && cpu_we) begin
                     m_mem[m_addr]   = cpu_data;
                     m_known[m_addr] = 1'b1;
                  end
                  if (finished) begin
                     m_state = 4;
                     m_ptr   = DUMP_BASE % DEPTH;
                  end
               end
            4: if (out_ready) begin
                  if (m_ptr == LAST_PTR) m_state = 5;
                  m_ptr = (m_ptr + 1) % DEPTH;
               end
            5: if (load_start) begin
                  m_state = 1;
                  m_ptr   = 0;
               end
            default: m_state = 0;
         endcase
         m_clkq = cpu_clk;
      end
   end

   // Compare process: every output against the model, away from the edge.
   always @(negedge clk) begin
      checkOutput("STATE", 32'(state), 32'(m_state));
      checkOutput("HOST_READY", 32'(host_ready), 32'(m_state == 1));
      checkOutput("START_PROCESSING_FLAG", 32'(start_flag), 32'(m_state == 3));
      checkOutput("OUT_VALID", 32'(out_valid), 32'(m_state == 4));
      checkOutput("OUT_LAST", 32'(out_last), 32'(m_state == 4 && m_ptr == LAST_PTR));
      if (m_rd_known) checkOutput("DATA_FROM_RAM", 32'(data_from_ram), 32'(m_rd));
      if (m_state == 4 && m_known[m_ptr])
         checkOutput("OUT_DATA", 32'(out_data), 32'(m_mem[m_ptr]));
   end

   // Drives CPU_CLOCK with a 16-cycle period for n cycles. In fixed mode the
   // write data equals edge_data only on the falling-edge cycle, so any write
   // outside that cycle leaves a different byte behind.
   task automatic cpuRun(input int n, input bit rand_mode, input logic [15:0] addr,
                         input logic [7:0] edge_data);
      logic prev;
      for (int i = 0; i < n; i++) begin
         prev      = cpu_clk;
         cpu_clk   = (cpu_phase < 8);
         cpu_phase = (cpu_phase + 1) % 16;
         if (rand_mode) begin
            cpu_addr = 16'($urandom);
            if ($urandom_range(0, 1) == 1) cpu_addr[7:0] = 8'($urandom_range(0, 31));
            cpu_data = 8'($urandom);
            cpu_we   = 1'($urandom_range(0, 1));
         end else begin
            cpu_we   = 1'b1;
            cpu_addr = addr;
            cpu_data = (prev && !cpu_clk) ? edge_data : 8'($urandom);
         end
         applyStimulus(1);
      end
   endtask

   // Random-length load with random gaps in HOST_VALID.
   task automatic hostLoad(input int len);
      int sent;
      sent = 0;
      while (sent < len) begin
         host_valid = ($urandom_range(0, 3) != 0);
         host_data  = 8'($urandom);
         host_last  = host_valid && (sent == len - 1);
         if (host_valid) sent++;
         applyStimulus(1);
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
   endtask

   // Drains a dump with random OUT_READY, bounded by a cycle budget.
   task automatic drainDump();
      for (int c = 0; c < 200 && state != 3'd5; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         applyStimulus(1);
      end
      out_ready = 1'b0;
      checkOutput("dump reaches DONE", 32'(state), 32'd5);
   endtask

   initial begin
      int beats;
      logic [7:0] exp_byte;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      rst_n      = 1'b0;
      load_start = 1'b0;
      host_run   = 1'b0;
      host_valid = 1'b0;
      host_data  = 8'h00;
      host_last  = 1'b0;
      cpu_clk    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = 16'h0000;
      cpu_data   = 8'h00;
      finished   = 1'b0;
      out_ready  = 1'b0;

      applyStimulus(3);
      checkOutput("reset STATE", 32'(state), 32'd0);
      checkOutput("reset DATA_FROM_RAM", 32'(data_from_ram), 32'h00);
      checkOutput("reset OUT_VALID", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1);

      $display("[TB] HOST_RUN in IDLE, then 4-byte load");
      host_run = 1'b1;
      applyStimulus(1);
      host_run   = 1'b0;
      load_start = 1'b1;
      applyStimulus(1);
      load_start = 1'b0;
      checkOutput("HOST_READY after start", 32'(host_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         host_valid = 1'b1;
         host_data  = 8'(8'h11 * (i + 1));
         host_last  = (i == 3);
         applyStimulus(1);
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
      checkOutput("STATE after 4th beat", 32'(state), 32'd2);
      host_run = 1'b1;
      applyStimulus(1);
      host_run = 1'b0;
      checkOutput("flag after HOST_RUN", 32'(start_flag), 32'd1);
      cpu_addr = 16'h0002;
      applyStimulus(1);
      checkOutput("read addr 2", 32'(data_from_ram), 32'h33);
      cpuRun(100, 1'b1, 16'h0, 8'h0);
      cpu_we   = 1'b0;
      finished = 1'b1;
      applyStimulus(1);
      finished = 1'b0;
      drainDump();

      $display("[TB] 256-byte load without HOST_LAST");
      load_start = 1'b1;
      applyStimulus(1);
      load_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         load_bytes[i] = 8'($urandom);
         host_valid    = 1'b1;
         host_data     = load_bytes[i];
         applyStimulus(1);
      end
      host_valid = 1'b0;
      checkOutput("STATE after byte 255", 32'(state), 32'd2);
      checkOutput("HOST_READY after byte 255", 32'(host_ready), 32'd0);

      $display("[TB] CPU write attempts in READY, then RUN writes");
      cpuRun(40, 1'b0, 16'h0105, 8'h5A);
      cpu_we   = 1'b0;
      host_run = 1'b1;
      applyStimulus(1);
      host_run = 1'b0;
      cpu_addr = 16'h0105;
      applyStimulus(1);
      checkOutput("READY write ignored", 32'(data_from_ram), 32'(load_bytes[5]));
      cpu_addr = 16'h00FF;
      applyStimulus(1);
      checkOutput("mem[0xFF] last load byte", 32'(data_from_ram), 32'(load_bytes[255]));
      cpuRun(64, 1'b0, 16'h0105, 8'hA5);
      cpu_we   = 1'b0;
      applyStimulus(1);
      checkOutput("mem[5] after RUN writes", 32'(data_from_ram), 32'hA5);
      cpu_clk = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cpu_we   = 1'b1;
         cpu_data = 8'($urandom);
         applyStimulus(1);
      end
      cpu_we = 1'b0;
      applyStimulus(1);
      checkOutput("no write with CPU_CLOCK high", 32'(data_from_ram), 32'hA5);

      $display("[TB] dump with OUT_READY toggling");
      finished = 1'b1;
      applyStimulus(1);
      finished = 1'b0;
      checkOutput("flag after finish", 32'(start_flag), 32'd0);
      checkOutput("OUT_VALID after finish", 32'(out_valid), 32'd1);
      beats = 0;
      for (int c = 0; c < 80 && beats < DUMP_LEN; c++) begin
         out_ready = (c % 2 == 1);
         if (out_valid && out_ready) begin
            beat_data[beats] = out_data;
            beat_last[beats] = out_last;
            beats++;
         end
         applyStimulus(1);
      end
      out_ready = 1'b0;
      checkOutput("dump beat count", 32'(beats), 32'(DUMP_LEN));
      checkOutput("STATE after dump", 32'(state), 32'd5);
      for (int i = 0; i < beats; i++) begin
         exp_byte = (i == 5) ? 8'hA5 : load_bytes[i];
         checkOutput("dump beat data", 32'(beat_data[i]), 32'(exp_byte));
         checkOutput("dump beat last", 32'(beat_last[i]), 32'(i == DUMP_LEN - 1));
      end

      $display("[TB] reset during load, then reload");
      host_run = 1'b1;
      applyStimulus(1);
      host_run   = 1'b0;
      load_start = 1'b1;
      applyStimulus(1);
      load_start = 1'b0;
      host_valid = 1'b1;
      host_data  = 8'hC1;
      applyStimulus(1);
      host_data  = 8'hC2;
      applyStimulus(1);
      host_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async reset STATE", 32'(state), 32'd0);
      checkOutput("async reset HOST_READY", 32'(host_ready), 32'd0);
      checkOutput("async reset DATA_FROM_RAM", 32'(data_from_ram), 32'h00);
      applyStimulus(2);
      rst_n      = 1'b1;
      load_start = 1'b1;
      applyStimulus(1);
      load_start = 1'b0;
      host_valid = 1'b1;
      host_data  = 8'hD0;
      host_last  = 1'b1;
      applyStimulus(1);
      host_valid = 1'b0;
      host_last  = 1'b0;
      host_run   = 1'b1;
      applyStimulus(1);
      host_run = 1'b0;
      cpu_addr = 16'h0001;
      applyStimulus(1);
      checkOutput("mem[1] kept over reset", 32'(data_from_ram), 32'hC2);
      finished = 1'b1;
      applyStimulus(1);
      finished = 1'b0;
      drainDump();

      $display("[TB] randomized sessions");
      for (int s = 0; s < 6; s++) begin
         host_run   = 1'b1;
         applyStimulus(1);
         host_run   = 1'b0;
         load_start = 1'b1;
         applyStimulus(1);
         load_start = 1'b0;
         hostLoad($urandom_range(1, 40));
         if ($urandom_range(0, 1) == 1) begin
            load_start = 1'b1;
            host_run   = 1'b1;
            applyStimulus(1);
            load_start = 1'b0;
            host_run   = 1'b0;
            hostLoad($urandom_range(1, 20));
         end
         host_run = 1'b1;
         applyStimulus(1);
         host_run = 1'b0;
         cpuRun($urandom_range(64, 160), 1'b1, 16'h0, 8'h0);
         finished = 1'b1;
         cpuRun(1, 1'b1, 16'h0, 8'h0);
         finished = 1'b0;
         cpu_we   = 1'b0;
         drainDump();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
